// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver that turns arrow/WASD make/break sequences into a held
// 5-bit direction code for the game timer, with framing, parity and timeout checks.
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic       key_event,
  output logic       frame_error
);

  localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] KS_NONE = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_e;

  // ---------------- synchronizers and edge detect ----------------
  logic [1:0] ps2_clk_sync_q,  ps2_clk_sync_d;
  logic [1:0] ps2_data_sync_q, ps2_data_sync_d;
  logic       ps2_clk_prev_q,  ps2_clk_prev_d;
  logic       fall;
  logic       din;

  always_comb begin
    ps2_clk_sync_d  = {ps2_clk_sync_q[0], ps2_clk};
    ps2_data_sync_d = {ps2_data_sync_q[0], ps2_data};
    ps2_clk_prev_d  = ps2_clk_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_sync_q  <= 2'b11;
      ps2_data_sync_q <= 2'b11;
      ps2_clk_prev_q  <= 1'b1;
    end else begin
      ps2_clk_sync_q  <= ps2_clk_sync_d;
      ps2_data_sync_q <= ps2_data_sync_d;
      ps2_clk_prev_q  <= ps2_clk_prev_d;
    end
  end

  assign fall = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
  assign din  = ps2_data_sync_q[1];

  // ---------------- frame receiver ----------------
  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          parity_ok_q;
  logic          byte_done_q;
  logic [7:0]    byte_q;
  logic          frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      parity_ok_q <= 1'b0;
      byte_done_q <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_q <= '0;
        if (fall && !din) begin
          state_q   <= S_DATA;
          bit_cnt_q <= '0;
          shift_q   <= '0;
        end
      end else if (!fall) begin
        // Keyboard stalled mid-frame: abandon the partial byte.
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= S_IDLE;
          tmo_q       <= '0;
          bit_cnt_q   <= '0;
          shift_q     <= '0;
          frame_err_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
        case (state_q)
          S_DATA: begin
            shift_q   <= {din, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            parity_ok_q <= ^{shift_q, din};
            state_q     <= S_STOP;
          end
          S_STOP: begin
            if (din && parity_ok_q) begin
              byte_done_q <= 1'b1;
              byte_q      <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- scan-code decode ----------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [4:0] keystroke_q, keystroke_d;
  logic       key_event_q, key_event_d;
  logic       map_hit;
  logic [4:0] map_code;
  logic [4:0] next_ks;

  always_comb begin
    map_hit  = 1'b0;
    map_code = KS_NONE;
    if (ext_q) begin
      case (byte_q)
        8'h75: begin map_hit = 1'b1; map_code = 5'b00100; end
        8'h72: begin map_hit = 1'b1; map_code = 5'b00101; end
        8'h6B: begin map_hit = 1'b1; map_code = 5'b00110; end
        8'h74: begin map_hit = 1'b1; map_code = 5'b00111; end
        default: ;
      endcase
    end else begin
      case (byte_q)
        8'h1D: begin map_hit = 1'b1; map_code = 5'b00000; end
        8'h1B: begin map_hit = 1'b1; map_code = 5'b00001; end
        8'h1C: begin map_hit = 1'b1; map_code = 5'b00010; end
        8'h23: begin map_hit = 1'b1; map_code = 5'b00011; end
        default: ;
      endcase
    end
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    keystroke_d = keystroke_q;
    key_event_d = 1'b0;
    next_ks     = keystroke_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // A break only releases the code if it is the one currently held.
        if (map_hit) begin
          if (!brk_q)                       next_ks = map_code;
          else if (map_code == keystroke_q) next_ks = KS_NONE;
        end
        if (next_ks != keystroke_q) begin
          keystroke_d = next_ks;
          key_event_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      keystroke_q <= KS_NONE;
      key_event_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      keystroke_q <= keystroke_d;
      key_event_q <= key_event_d;
    end
  end

  assign keystroke   = keystroke_q;
  assign key_event   = key_event_q;
  assign frame_error = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: directed scenarios plus random scan-code
// streams, compared against a table-driven keyboard model.
module tb_ps2_direction_decoder;
  localparam int TMO = 1000;

  logic       gclk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data;
  logic [4:0] keystroke;
  logic       key_event, frame_error;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(gclk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keystroke(keystroke), .key_event(key_event), .frame_error(frame_error)
  );

  always #5 gclk = ~gclk;

  int cyc = 0;
  int ev_cnt = 0, fe_cnt = 0, last_ev_cyc = 0, last_fe_cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;
  always @(negedge gclk) begin
    if (!reset) begin
      if (key_event)   begin ev_cnt <= ev_cnt + 1; last_ev_cyc <= cyc; end
      if (frame_error) begin fe_cnt <= fe_cnt + 1; last_fe_cyc <= cyc; end
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: key tables indexed by direction code.
  logic [7:0] key_tab [8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};
  logic [4:0] m_ks = 5'b10000;
  bit m_ext = 0, m_brk = 0;
  int m_ev = 0, m_fe = 0;

  function automatic bit model_byte(input logic [7:0] b);
    logic [4:0] nk;
    nk = m_ks;
    if (b == 8'hE0) begin m_ext = 1; return 0; end
    if (b == 8'hF0) begin m_brk = 1; return 0; end
    for (int i = 0; i < 8; i++)
      if (key_tab[i] == b && (i >= 4) == m_ext) begin
        if (!m_brk) nk = 5'(i);
        else if (m_ks == 5'(i)) nk = 5'b10000;
      end
    m_ext = 0; m_brk = 0;
    if (nk != m_ks) begin m_ks = nk; m_ev++; return 1; end
    return 0;
  endfunction

  int half = 10;
  int fall_cyc = 0;

  task automatic ps2_bit(input logic b);
    @(negedge gclk); ps2_data = b;
    repeat (half) @(negedge gclk);
    ps2_clk = 1'b0; fall_cyc = cyc;
    repeat (half) @(negedge gclk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input string tag);
    bit changed;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad);
    ps2_bit(1'b1);
    repeat (2 * half + 4) @(negedge gclk);
    changed = 0;
    if (bad) begin m_fe++; m_ext = 0; m_brk = 0; end
    else changed = model_byte(b);
    if (changed) chk({tag, " latency"}, last_ev_cyc - fall_cyc, 4);
    chk({tag, " keystroke"}, keystroke, m_ks);
    chk({tag, " events"}, ev_cnt, m_ev);
    chk({tag, " frame_err"}, fe_cnt, m_fe);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge gclk);
    reset = 1'b0;
    m_ks = 5'b10000; m_ext = 0; m_brk = 0;
    @(negedge gclk);
  endtask

  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75,
                            8'h72, 8'h6B, 8'h74, 8'h2A, 8'h55, 8'hE0, 8'hF0};
  int t0;
  int fe0;

  initial begin
    ps2_clk = 1'b1; ps2_data = 1'b1; reset = 1'b1;
    repeat (3) @(negedge gclk);
    chk("rst keystroke", keystroke, 5'b10000);
    chk("rst key_event", key_event, 0);
    chk("rst frame_error", frame_error, 0);
    reset = 1'b0;
    repeat (2) @(negedge gclk);

    // press and release W
    send_frame(8'h1D, 0, "w make");
    send_frame(8'hF0, 0, "w f0");
    send_frame(8'h1D, 0, "w brk");
    // extended right with typematic repeat, then release
    send_frame(8'hE0, 0, "r e0");  send_frame(8'h74, 0, "r make");
    send_frame(8'hE0, 0, "r e0b"); send_frame(8'h74, 0, "r rep");
    send_frame(8'hE0, 0, "r e0c"); send_frame(8'hF0, 0, "r f0");
    send_frame(8'h74, 0, "r brk");
    // bad parity
    send_frame(8'h1C, 1, "parity");
    // timeout: start + 3 data bits then silence
    fe0 = fe_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    t0 = fall_cyc;
    for (int i = 0; i < 2 * TMO && fe_cnt == fe0; i++) @(negedge gclk);
    m_fe++;
    chk("tmo fe", fe_cnt, m_fe);
    chk("tmo cycle", last_fe_cyc - t0, TMO + 3);
    send_frame(8'h1B, 0, "after tmo");
    // hold left, release a non-held key, then an unmapped byte
    send_frame(8'hE0, 0, "l e0"); send_frame(8'h6B, 0, "l make");
    send_frame(8'hF0, 0, "x f0"); send_frame(8'h1D, 0, "x brk");
    send_frame(8'hF0, 0, "u f0"); send_frame(8'h2A, 0, "unmapped");
    send_frame(8'h1D, 0, "flags clr");
    // reset in the middle of bit 5
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    @(negedge gclk); ps2_data = 1'b0;
    repeat (half) @(negedge gclk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge gclk);
    reset = 1'b1;
    repeat (3) @(negedge gclk);
    ps2_clk = 1'b1;
    do_reset();
    chk("midrst ks", keystroke, 5'b10000);
    chk("midrst fe", fe_cnt, fe0);
    send_frame(8'h23, 0, "post rst");

    // random scan-code stream
    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(6, 15);
      send_frame(pool[$urandom_range(0, 13)], ($urandom_range(0, 7) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
